serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor with borrow-in and borrow-out. Computes d = a - b - bin one bit per clock, LSB first.
- Companion to the datapath's combinational adder. Provides subtraction for area-constrained paths where multi-cycle latency is acceptable.
- Uses a start/busy/done handshake. The result is registered and held stable until the next operation completes.

---
 rtl/sub_pkg.sv | 8 +
 rtl/full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 67 ++++++
 tb/tb_serial_subtractor.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and default width for the serial subtractor
package sub_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'b00;
  localparam state_t SHIFT = 2'b01;
  localparam state_t DONE  = 2'b10;
  localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - bi with difference and borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic dif,
  output logic bo
);
  assign dif = x ^ y ^ bi;
  assign bo  = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, start/busy/done handshake
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] sa, sb, acc;
  logic [WIDTH:0] ext;
  logic [CW-1:0] cnt;
  logic br, dif, bo, accept, last;
  full_subtractor u_fs (.x(sa[0]), .y(sb[0]), .bi(br), .dif(dif), .bo(bo));
  assign ext    = {dif, acc};
  assign accept = start && state != SHIFT;
  assign last   = cnt == CW'(WIDTH - 1);
  assign busy   = state == SHIFT;
  // FSM, operand shifting and result capture; a start in DONE restarts directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sa    <= a;
        sb    <= b;
        br    <= bin;
        acc   <= '0;
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        br  <= bo;
        acc <= ext[WIDTH:1];
        cnt <= cnt + CW'(1);
        if (last) begin
          d     <= ext[WIDTH:1];
          bout  <= bo;
          done  <= 1'b1;
          state <= DONE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of the serial subtractor
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic bin = 1'b0;
  logic busy, done, bout;
  logic [3:0] d;
  int cmp = 0;
  int err = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [3:0] xa, input logic [3:0] xb, input logic xbin);
    @(negedge clk);
    a = xa; b = xb; bin = xbin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n: negedge index (1 = right after start edge) where done was seen, 0 if never
  task automatic wait_done(output int n, output int nbusy);
    n = 0; nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    #12;
    cmp++;
    if ({busy, done, d, bout} !== 7'b0) begin
      err++; $display("FAIL reset: busy/done/d/bout=%b required 0000000", {busy, done, d, bout});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [3:0] va [4] = '{4'd9, 4'd3, 4'd0, 4'd5};
    logic [3:0] vb [4] = '{4'd3, 4'd9, 4'd0, 4'd5};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] ex [4] = '{5'b0_0110, 5'b1_1010, 5'b1_1111, 5'b0_0000};
    int n, nb;
    for (int i = 0; i < 4; i++) begin
      launch(va[i], vb[i], vc[i]);
      wait_done(n, nb);
      cmp++;
      if (n !== 5 || nb !== 4) begin
        err++; $display("FAIL directed%0d timing: done at %0d busy %0d required 5/4", i, n, nb);
      end
      cmp++;
      if ({bout, d} !== ex[i]) begin
        err++; $display("FAIL directed%0d result: bout,d=%b required %b", i, {bout, d}, ex[i]);
      end
      @(negedge clk);
      cmp++;
      if (done !== 1'b0 || {bout, d} !== ex[i]) begin
        err++; $display("FAIL directed%0d hold: done=%b bout,d=%b required 0/%b", i, done, {bout, d}, ex[i]);
      end
    end
  endtask

  task automatic test_sweep;
    logic [4:0] ex;
    int n, nb;
    for (int i = 0; i < 512; i++) begin
      ex = {1'b0, 4'(i >> 5)} - {1'b0, 4'(i >> 1)} - {4'b0, 1'(i)};
      launch(4'(i >> 5), 4'(i >> 1), 1'(i));
      wait_done(n, nb);
      cmp++;
      if (n !== 5 || nb !== 4 || {bout, d} !== ex) begin
        err++;
        $display("FAIL sweep a=%0d b=%0d bin=%0d: done@%0d busy %0d bout,d=%b required 5/4/%b",
                 i >> 5, (i >> 1) & 15, i & 1, n, nb, {bout, d}, ex);
      end
    end
  endtask

  task automatic test_mid_start;
    int nd = 0;
    logic [4:0] got = '0;
    launch(4'd12, 4'd5, 1'b0);
    @(negedge clk);
    a = 4'd1; b = 4'd2; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin nd++; got = {bout, d}; end
    end
    cmp++;
    if (nd !== 1 || got !== 5'b0_0111) begin
      err++; $display("FAIL mid_start: dones=%0d bout,d=%b required 1/00111", nd, got);
    end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    launch(4'd7, 4'd2, 1'b0);
    wait_done(n, nb);
    cmp++;
    if (n !== 5 || {bout, d} !== 5'b0_0101) begin
      err++; $display("FAIL b2b first: done@%0d bout,d=%b required 5/00101", n, {bout, d});
    end
    a = 4'd2; b = 4'd7; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || {bout, d} !== 5'b0_0101) begin
        err++; $display("FAIL b2b hold%0d: busy=%b done=%b bout,d=%b required 1/0/00101", i, busy, done, {bout, d});
      end
    end
    @(negedge clk);
    cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || {bout, d} !== 5'b1_1011) begin
      err++; $display("FAIL b2b second: done=%b busy=%b bout,d=%b required 1/0/11011", done, busy, {bout, d});
    end
  endtask

  task automatic test_async_reset;
    int nd = 0;
    int n, nb;
    launch(4'd9, 4'd3, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({busy, done, d, bout} !== 7'b0) begin
      err++; $display("FAIL async_reset: busy/done/d/bout=%b required 0000000", {busy, done, d, bout});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    cmp++;
    if (nd !== 0 || d !== 4'd0) begin
      err++; $display("FAIL after_reset: busy/done cycles=%0d d=%0d required 0/0", nd, d);
    end
    launch(4'd9, 4'd3, 1'b0);
    wait_done(n, nb);
    cmp++;
    if (n !== 5 || nb !== 4 || {bout, d} !== 5'b0_0110) begin
      err++; $display("FAIL restart: done@%0d busy %0d bout,d=%b required 5/4/00110", n, nb, {bout, d});
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_sweep;
    test_mid_start;
    test_back_to_back;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
